lsu_tlul_host: RTL

- Upstream host adapter for the data memory TL-UL device.
- Converts the core load/store unit's req/gnt/rvalid data interface into registered TL-UL A-channel requests, with a bounded number of outstanding transactions.
- Returns D-channel responses to the core in order, with error reporting.
- Sits between the core LSU and the TL-UL crossbar/data memory port.

---
 rtl/tlul_pkg.sv | 57 +++++
 rtl/lsu_tlul_host.sv | 127 ++++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package shared by the LSU host adapter and its environment.
// Field layout follows the usual h2d/d2h split with a_ready/d_ready on the opposite channel.
package tlul_pkg;

   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_DBW = 4;
   localparam int TL_SZW = 2;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic [3:0] instr_type;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   localparam tl_a_user_t TL_A_USER_DEFAULT = '{instr_type: 4'h9, cmd_intg: 7'h0, data_intg: 7'h0};

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      tl_a_user_t        a_user;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      tl_d_user_t        d_user;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/lsu_tlul_host.sv
// LSU req/gnt/rvalid to TL-UL host adapter: one registered A beat at a time,
// up to Outstanding requests in flight, in-order registered responses with error flagging.
module lsu_tlul_host #(
   parameter int unsigned Outstanding = 2,
   parameter int unsigned SourceW     = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 data_req_i,
   output logic                 data_gnt_o,
   input  logic                 data_we_i,
   input  logic [3:0]           data_be_i,
   input  logic [31:0]          data_addr_i,
   input  logic [31:0]          data_wdata_i,
   output logic                 data_rvalid_o,
   output logic [31:0]          data_rdata_o,
   output logic                 data_err_o,
   output tlul_pkg::tl_h2d_t    tl_o,
   input  tlul_pkg::tl_d2h_t    tl_i
);

   localparam logic [2:0] CntMax  = 3'(Outstanding);
   localparam logic [1:0] TagLast = 2'(Outstanding - 1);

   logic               gnt, credit, d_acc;
   logic [2:0]         cnt_q;
   logic [1:0]         tag_iss_q, tag_exp_q;
   logic [SourceW-1:0] exp_src;

   logic               a_vld_p0;
   logic [2:0]         a_opcode_p0;
   logic [31:0]        a_address_p0;
   logic [3:0]         a_mask_p0;
   logic [31:0]        a_data_p0;
   logic [SourceW-1:0] a_source_p0;

   logic               rsp_vld_p1;
   logic [31:0]        rsp_rdata_p1;
   logic               rsp_err_p1;

   logic               unused_tl_d;

   function automatic logic [1:0] tag_inc(input logic [1:0] t);
      return (t == TagLast) ? 2'd0 : t + 2'd1;
   endfunction

   function automatic logic [2:0] a_opcode_f(input logic we, input logic [3:0] be);
      if (!we)            return tlul_pkg::Get;
      else if (be == 4'hF) return tlul_pkg::PutFullData;
      else                return tlul_pkg::PutPartialData;
   endfunction

   assign credit     = (cnt_q < CntMax);
   assign gnt        = data_req_i & ~a_vld_p0 & credit & ~rst_i;
   assign data_gnt_o = gnt;
   // d_ready is constant 1, so every d_valid is a beat; beats with nothing in flight are ignored
   assign d_acc      = tl_i.d_valid & (cnt_q != 3'd0);
   assign exp_src    = SourceW'(tag_exp_q);

   // Stage p0: A-channel request register
   always_ff @(posedge clk_i) begin
      if (rst_i)             a_vld_p0 <= 1'b0;
      else if (gnt)          a_vld_p0 <= 1'b1;
      else if (tl_i.a_ready) a_vld_p0 <= 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (gnt) begin
         a_opcode_p0  <= a_opcode_f(data_we_i, data_be_i);
         a_address_p0 <= {data_addr_i[31:2], 2'b00};
         a_mask_p0    <= data_we_i ? data_be_i : 4'hF;
         a_data_p0    <= data_we_i ? data_wdata_i : 32'h0;
         a_source_p0  <= SourceW'(tag_iss_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= 3'd0;
         tag_iss_q <= 2'd0;
         tag_exp_q <= 2'd0;
      end else begin
         if (gnt && !d_acc)      cnt_q <= cnt_q + 3'd1;
         else if (!gnt && d_acc) cnt_q <= cnt_q - 3'd1;
         if (gnt)   tag_iss_q <= tag_inc(tag_iss_q);
         if (d_acc) tag_exp_q <= tag_inc(tag_exp_q);
      end
   end

   // Stage p1: registered response toward the core
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_vld_p1   <= 1'b0;
         rsp_rdata_p1 <= 32'h0;
         rsp_err_p1   <= 1'b0;
      end else begin
         rsp_vld_p1 <= d_acc;
         if (d_acc) begin
            if (tl_i.d_opcode == tlul_pkg::AccessAckData) rsp_rdata_p1 <= tl_i.d_data;
            rsp_err_p1 <= tl_i.d_error | (tl_i.d_source != exp_src) |
                          ((tl_i.d_opcode != tlul_pkg::AccessAck) &&
                           (tl_i.d_opcode != tlul_pkg::AccessAckData));
         end
      end
   end

   assign data_rvalid_o = rsp_vld_p1;
   assign data_rdata_o  = rsp_rdata_p1;
   assign data_err_o    = rsp_err_p1;

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = a_vld_p0;
      tl_o.a_opcode  = a_opcode_p0;
      tl_o.a_param   = 3'd0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = a_source_p0;
      tl_o.a_address = a_address_p0;
      tl_o.a_mask    = a_mask_p0;
      tl_o.a_data    = a_data_p0;
      tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
      tl_o.d_ready   = 1'b1;
   end

   assign unused_tl_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, data_addr_i[1:0]};

endmodule
